// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit, also used by the controller
// and hazard unit: operation encodings, read-select encodings, default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  localparam logic HILO_LO = 1'b0;
  localparam logic HILO_HI = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mdu_if.sv
// Controller-side bundle of the multiply/divide unit: operands, request, read
// select, and the busy/outcome responses.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        start;
  logic        HiLoSel;
  logic        busy;
  logic [31:0] outcome;

  modport master (output A, B, MDOp, start, HiLoSel, input busy, outcome);
  modport slave  (input A, B, MDOp, start, HiLoSel, output busy, outcome);
endinterface

// File: rtl/mdu_core.sv
// Combinational multiply/divide datapath producing {hi, lo}; divide is done on
// magnitudes with the signs restored afterwards, so truncation is toward zero.
module mdu_core (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  input  logic        div_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic        a_neg_s;
  logic        b_neg_s;
  logic        ovf_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] b_safe_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [63:0] prod_s;

  // Operand conditioning, arithmetic and result selection.
  always_comb begin
    a_neg_s    = signed_i & a_i[31];
    b_neg_s    = signed_i & b_i[31];
    a_mag_s    = a_neg_s ? (32'd0 - a_i) : a_i;
    b_mag_s    = b_neg_s ? (32'd0 - b_i) : b_i;
    div_zero_o = (b_i == 32'd0);
    ovf_s      = signed_i & (a_i == 32'h8000_0000) & (b_i == 32'hFFFF_FFFF);
    // A zero divisor is replaced so the divider never produces X; the result is dropped anyway.
    b_safe_s   = div_zero_o ? 32'd1 : b_mag_s;
    q_mag_s    = a_mag_s / b_safe_s;
    r_mag_s    = a_mag_s % b_safe_s;
    quo_s      = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s      = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
    if (signed_i) begin
      prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    end else begin
      prod_s = {32'd0, a_i} * {32'd0, b_i};
    end
    if (!div_i) begin
      result_o = prod_s;
    end else if (ovf_s) begin
      result_o = {32'd0, 32'h8000_0000};
    end else begin
      result_o = {rem_s, quo_s};
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO: computes at accept, holds the
// result in pending registers and commits it after the configured latency.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  md_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [63:0] pend_q, pend_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_s;
  logic        div_s;
  logic [63:0] core_res_s;
  logic        core_dz_s;

  assign signed_s = (bus.MDOp == MD_MULT) | (bus.MDOp == MD_DIV);
  assign div_s    = (bus.MDOp == MD_DIV)  | (bus.MDOp == MD_DIVU);

  mdu_core u_core (
    .a_i        (bus.A),
    .b_i        (bus.B),
    .signed_i   (signed_s),
    .div_i      (div_s),
    .result_o   (core_res_s),
    .div_zero_o (core_dz_s)
  );

  // Next-state logic: accept in IDLE, count down while busy, commit on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (md_op_e'(bus.MDOp))
            MD_MULT, MD_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = 16'(MULT_CYCLES);
              busy_d  = 1'b1;
              pend_d  = core_res_s;
              dz_d    = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_d = ST_DIV;
              cnt_d   = 16'(DIV_CYCLES);
              busy_d  = 1'b1;
              pend_d  = core_res_s;
              dz_d    = core_dz_s;
            end
            MD_MTHI: hi_d = bus.A;
            MD_MTLO: lo_d = bus.A;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == 16'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          busy_d  = 1'b0;
          // A zero divisor leaves the architectural registers untouched.
          if (!dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end else begin
            hi_d = hi_q;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter, pending and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      busy_q  <= 1'b0;
      pend_q  <= 64'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.outcome = (bus.HiLoSel == HILO_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table with a result scoreboard, plus
// hand sequences for ignored requests during busy and asynchronous reset.
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  exp_t        sb[$];
  vec_t        vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.MDOp  = MD_NONE;
  endtask

  // Counts busy cycles (bounded) while checking outcome still shows committed values.
  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      bus.HiLoSel = n[0];
      #1;
      check({name, " hold"}, bus.outcome, n[0] ? m_hi : m_lo);
      n++;
      tick();
    end
  endtask

  task automatic check_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    bus.HiLoSel = HILO_HI;
    #1;
    check({name, " HI"}, bus.outcome, hi);
    bus.HiLoSel = HILO_LO;
    #1;
    check({name, " LO"}, bus.outcome, lo);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    issue(v.op, v.a, v.b);
    sb.push_back('{v.hi, v.lo, v.cyc});
    wait_idle(v.name, n);
    e = sb.pop_front();
    check({v.name, " busy cycles"}, 32'(n), 32'(e.cyc));
    check_hilo(v.name, e.hi, e.lo);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    vecs[0]  = '{"mult -2*3",     MD_MULT,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{"multu max*max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{"div -7/2",      MD_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{"mthi",          MD_MTHI,  32'h11,        32'h0,         32'h11,        32'hFFFF_FFFD, 0};
    vecs[4]  = '{"mtlo",          MD_MTLO,  32'h22,        32'h0,         32'h11,        32'h22,        0};
    vecs[5]  = '{"divu 7/0",      MD_DIVU,  32'h7,         32'h0,         32'h11,        32'h22,        10};
    vecs[6]  = '{"div min/-1",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 10};
    vecs[7]  = '{"divu 100/7",    MD_DIVU,  32'd100,       32'd7,         32'h2,         32'hE,         10};
    vecs[8]  = '{"div 7/-2",      MD_DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 10};
    vecs[9]  = '{"mult min*min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         5};
    vecs[10] = '{"none",          MD_NONE,  32'h99,        32'h99,        32'h4000_0000, 32'h0,         0};
    vecs[11] = '{"reserved",      MD_RSVD,  32'h99,        32'h99,        32'h4000_0000, 32'h0,         0};
    vecs[12] = '{"div 5/0",       MD_DIV,   32'h5,         32'h0,         32'h4000_0000, 32'h0,         10};

    reset       = 1'b0;
    bus.A       = 32'd0;
    bus.B       = 32'd0;
    bus.MDOp    = MD_NONE;
    bus.start   = 1'b0;
    bus.HiLoSel = HILO_LO;
    #3;
    check("reset busy", 32'(bus.busy), 32'd0);
    check_hilo("reset", 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post-reset busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
    end

    // Requests during busy must be ignored.
    issue(MD_MULT, 32'd6, 32'd7);
    sb.push_back('{32'h0, 32'h2A, 5});
    n = 0;
    check("ignore busy up", 32'(bus.busy), 32'd1);
    tick();
    n++;
    bus.MDOp  = MD_MTLO;
    bus.A     = 32'h55;
    bus.start = 1'b1;
    tick();
    n++;
    bus.MDOp  = MD_MULT;
    bus.A     = 32'd100;
    bus.B     = 32'd100;
    tick();
    n++;
    bus.start = 1'b0;
    bus.MDOp  = MD_NONE;
    begin
      int rem;
      wait_idle("ignore", rem);
      n += rem;
    end
    e = sb.pop_front();
    check("ignore busy cycles", 32'(n), 32'(e.cyc));
    check_hilo("ignore", e.hi, e.lo);
    m_hi = e.hi;
    m_lo = e.lo;

    // Asynchronous reset in the middle of a divide.
    issue(MD_DIV, 32'd100, 32'd3);
    sb.push_back('{32'h1, 32'h21, 10});
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check_hilo("abort", 32'd0, 32'd0);
    sb.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("abort stays idle", 32'(bus.busy), 32'd0);
    run_vec('{"mult 3*4", MD_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 5});
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage of the pipelined MIPS core.
- It accepts operands and an operation code from the controller, holds a busy handshake back to the hazard unit while it works, and owns the HI/LO architectural registers.
- It serves MULT/MULTU/DIV/DIVU/MTHI/MTLO, and MFHI/MFLO through a read port.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- A  input  32  operand rs.
- B  input  32  operand rt.
- MDOp  input  3  operation: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE).
- start  input  1  one-cycle request qualifier for MDOp.
- HiLoSel  input  1  read select: 0 = LO, 1 = HI.
- busy  output  1  high while an operation is in flight.
- outcome  output  32  HI or LO per HiLoSel (combinational read of the registers).

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, state IDLE. outcome therefore reads 0.
- Reset asserted mid-operation aborts the operation. The pending result is discarded and HI/LO are zeroed.
- FSM states:
  - IDLE, MUL, DIV.
  - IDLE -> MUL on start & MDOp in {MULT, MULTU}.
  - IDLE -> DIV on start & MDOp in {DIV, DIVU}.
  - MUL/DIV -> IDLE when the counter reaches 1.
- Accept edge:
  - Latch A and B.
  - Compute the 64-bit product, or the quotient and remainder, into pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Raise busy on that same edge.
- busy is high for exactly MULT_CYCLES (or DIV_CYCLES) cycles after the accept edge.
- On the final edge: HI/LO <= pending, busy <= 0, state <= IDLE.
- The new HI/LO values are visible on outcome in the first cycle busy reads 0.
- Arithmetic:
  - MULT: signed 32x32 -> 64 product, HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32 -> 64 product, same HI/LO split.
  - DIV: signed division truncated toward zero. LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
  - DIVU: unsigned division, LO=quotient, HI=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
  - Divide by zero (B=0) with DIV or DIVU: the unit still goes busy for DIV_CYCLES, then leaves HI and LO unchanged.
- MTHI/MTLO:
  - Accepted only in IDLE. Writes A into HI/LO on the accept edge.
  - busy stays 0, so the write is visible the next cycle.
- start while busy is ignored for every MDOp. Stalling the issuing instruction is the hazard unit's duty; the unit has no queueing.
- start with MDOp NONE or reserved: no effect.
- outcome reads the committed HI/LO only, never the pending result. During busy it returns the pre-operation values.

Decomposition:
- Shared package holds:
  - MDOp encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - HiLoSel encodings.
  - Default latency constants.
- The same package is consumed by the controller and the hazard unit.
- One natural sub-module: mdu_core. It is the combinational signed/unsigned multiply and divide datapath that produces a 64-bit {hi, lo}, with the divide-by-zero flag and the 0x80000000/-1 special case.
- The top level keeps the FSM, the counter, the pending registers and HI/LO.

Test Plan:
- Reset, then MULT with A=0xFFFFFFFE (-2), B=3, start pulse:
  - busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - outcome shows the old value (0) while busy.
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF: after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV with A=0xFFFFFFF9 (-7), B=2: busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU with A=7, B=0 after a preload of HI=0x11, LO=0x22 via MTHI/MTLO: busy 10 cycles, then HI=0x11, LO=0x22 (unchanged).
- MULT accepted, then MTLO A=0x55 and a second MULT pulsed at busy cycle 2: both are ignored, and the final HI/LO equal the first MULT's result only.
- DIV in flight, reset driven low at busy cycle 4 (asynchronously, mid-cycle): busy=0 and HI=LO=0 immediately. After release, a fresh MULT 3*4 yields LO=12, HI=0.
